// File: rtl/note_pkg.sv
// ---------------------------------------------------------------------------
// note_pkg : shared types and the frequency-to-MIDI band table
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package note_pkg;

    localparam int FREQ_W_DEF = 32;
    localparam int NOTE_W_DEF = 8;

    typedef logic [NOTE_W_DEF-1:0] note_t;

    localparam note_t REST_CODE = '0;
    localparam note_t OVER_CODE = '1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        PLAY    = 2'd2
    } state_t;

    // Lower band edge of MIDI n is the geometric midpoint between n-1 and n,
    // i.e. 440 * 2^((n-69.5)/12), rounded to the nearest Hz.
    localparam int          FIRST_MIDI = 12;
    localparam int          NUM_BANDS  = 116;
    localparam int unsigned HI_BOUND   = 12911;

    localparam int unsigned LO_BOUND [NUM_BANDS] = '{
           16,    17,    18,    19,    20,    21,    22,    24,    25,    27,    28,    30,
           32,    34,    36,    38,    40,    42,    45,    48,    50,    53,    57,    60,
           64,    67,    71,    76,    80,    85,    90,    95,   101,   107,   113,   120,
          127,   135,   143,   151,   160,   170,   180,   190,   202,   214,   226,   240,
          254,   269,   285,   302,   320,   339,   359,   381,   403,   427,   453,   480,
          508,   539,   571,   605,   640,   679,   719,   762,   807,   855,   906,   960,
         1017,  1077,  1141,  1209,  1281,  1357,  1438,  1523,  1614,  1710,  1812,  1919,
         2033,  2154,  2282,  2418,  2562,  2714,  2876,  3047,  3228,  3420,  3623,  3839,
         4067,  4309,  4565,  4836,  5124,  5429,  5751,  6093,  6456,  6840,  7246,  7677,
         8134,  8617,  9130,  9673, 10248, 10857, 11503, 12187
    };

endpackage

`default_nettype wire

// File: rtl/note_sequencer_if.sv
// ---------------------------------------------------------------------------
// note_sequencer_if : frequency input stream and note output stream
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface note_sequencer_if
    import note_pkg::*;
#(
    parameter int FREQ_W = FREQ_W_DEF,
    parameter int NOTE_W = NOTE_W_DEF
);
    logic              in_valid;
    logic              in_ready;
    logic [FREQ_W-1:0] in_freq;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [NOTE_W-1:0] out_note;
    logic              out_last;

    modport master (
        output in_valid, in_freq, in_last, out_ready,
        input  in_ready, out_valid, out_note, out_last
    );

    modport slave (
        input  in_valid, in_freq, in_last, out_ready,
        output in_ready, out_valid, out_note, out_last
    );
endinterface

`default_nettype wire

// File: rtl/freq_to_note.sv
// ---------------------------------------------------------------------------
// freq_to_note : combinational Hz -> MIDI code lookup against band table
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module freq_to_note
    import note_pkg::*;
#(
    parameter int FREQ_W = FREQ_W_DEF,
    parameter int NOTE_W = NOTE_W_DEF
) (
    input  wire logic [FREQ_W-1:0] freq_i,
    output logic      [NOTE_W-1:0] note_o
);
    localparam int EXT_W = (FREQ_W > 32) ? FREQ_W : 32;

    logic [EXT_W-1:0] w_freq;
    assign w_freq = EXT_W'(freq_i);

    // Bands are ascending, so the last matching lower edge wins.
    always_comb begin
        note_o = NOTE_W'(REST_CODE);
        for (int i = 0; i < NUM_BANDS; i++) begin
            if (w_freq >= EXT_W'(LO_BOUND[i])) begin
                note_o = NOTE_W'(FIRST_MIDI + i);
            end
        end
        if (w_freq >= EXT_W'(HI_BOUND)) begin
            note_o = {NOTE_W{1'b1}};
        end
    end

endmodule

`default_nettype wire

// File: rtl/note_sequencer.sv
// ---------------------------------------------------------------------------
// note_sequencer : captures a phrase of frequency samples as note codes into a
//                  buffer and plays it back once or looping. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module note_sequencer
    import note_pkg::*;
#(
    parameter int FREQ_W = FREQ_W_DEF,
    parameter int NOTE_W = NOTE_W_DEF,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  wire logic             clk,
    input  wire logic             reset_n,
    input  wire logic             start_capture,
    input  wire logic             start_play,
    input  wire logic             loop_en,
    input  wire logic             abort,
    note_sequencer_if.slave       bus,
    output logic      [CNT_W-1:0] count,
    output logic                  busy,
    output logic                  done
);
    localparam int PTR_W = $clog2(DEPTH);

    state_t            state_q;
    logic              in_ready_q, out_valid_q, out_last_q, done_q, loop_q;
    logic              pend_q;
    logic [CNT_W-1:0]  count_q, wr_cnt_q;
    logic [PTR_W-1:0]  rd_ptr_q, pend_addr_q;
    logic [NOTE_W-1:0] pend_note_q, rd_data_q;
    logic [NOTE_W-1:0] mem_q [DEPTH];

    logic [NOTE_W-1:0] w_conv_note;
    logic [PTR_W-1:0]  w_last_idx;
    logic              w_acc, w_adv, w_fin, w_rd_en, w_rd_last, w_wr_full;

    freq_to_note #(
        .FREQ_W (FREQ_W),
        .NOTE_W (NOTE_W)
    ) u_freq_to_note (
        .freq_i (bus.in_freq),
        .note_o (w_conv_note)
    );

    assign w_acc      = (state_q == CAPTURE) && in_ready_q && bus.in_valid;
    assign w_wr_full  = (wr_cnt_q == CNT_W'(DEPTH - 1));
    assign w_last_idx = PTR_W'(count_q - CNT_W'(1));
    assign w_rd_last  = (rd_ptr_q == w_last_idx);
    // The RAM output register doubles as the output holding register: it
    // only reloads when the current note is gone or is being taken.
    assign w_adv      = !out_valid_q || bus.out_ready;
    assign w_fin      = out_valid_q && out_last_q && !loop_q;
    assign w_rd_en    = (state_q == PLAY) && w_adv && !w_fin && !abort;

    always_ff @(posedge clk) begin
        if (pend_q) begin
            mem_q[pend_addr_q] <= pend_note_q;
        end
        if (w_rd_en) begin
            rd_data_q <= mem_q[rd_ptr_q];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
            loop_q      <= 1'b0;
            pend_q      <= 1'b0;
            count_q     <= '0;
            wr_cnt_q    <= '0;
            rd_ptr_q    <= '0;
            pend_addr_q <= '0;
            pend_note_q <= '0;
        end else begin
            done_q <= 1'b0;
            // A write accepted this cycle always lands, even if aborted.
            pend_q <= w_acc;
            if (w_acc) begin
                pend_note_q <= w_conv_note;
                pend_addr_q <= wr_cnt_q[PTR_W-1:0];
                wr_cnt_q    <= wr_cnt_q + CNT_W'(1);
            end

            if (abort) begin
                state_q     <= IDLE;
                in_ready_q  <= 1'b0;
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
                if (state_q == CAPTURE) begin
                    count_q <= wr_cnt_q + CNT_W'(w_acc);
                end
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start_capture) begin
                            state_q    <= CAPTURE;
                            in_ready_q <= 1'b1;
                            wr_cnt_q   <= '0;
                            count_q    <= '0;
                        end else if (start_play) begin
                            if (count_q == '0) begin
                                done_q <= 1'b1;
                            end else begin
                                state_q  <= PLAY;
                                loop_q   <= loop_en;
                                rd_ptr_q <= '0;
                            end
                        end
                    end
                    CAPTURE: begin
                        if (w_acc && (bus.in_last || w_wr_full)) begin
                            state_q    <= IDLE;
                            in_ready_q <= 1'b0;
                            done_q     <= 1'b1;
                            count_q    <= wr_cnt_q + CNT_W'(1);
                        end
                    end
                    PLAY: begin
                        if (w_adv) begin
                            if (w_fin) begin
                                state_q     <= IDLE;
                                out_valid_q <= 1'b0;
                                out_last_q  <= 1'b0;
                                done_q      <= 1'b1;
                            end else begin
                                out_valid_q <= 1'b1;
                                out_last_q  <= w_rd_last;
                                rd_ptr_q    <= w_rd_last ? '0 : rd_ptr_q + PTR_W'(1);
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_note  = out_valid_q ? rd_data_q : '0;
    assign count         = count_q;
    assign busy          = (state_q != IDLE);
    assign done          = done_q;

endmodule

`default_nettype wire

// File: tb/tb_note_sequencer.sv
// ---------------------------------------------------------------------------
// tb_note_sequencer : directed self-checking bench for note_sequencer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_note_sequencer;
    import note_pkg::*;

    localparam int DEPTH = 16;
    localparam int CNT_W = 5;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             start_capture = 1'b0;
    logic             start_play = 1'b0;
    logic             loop_en = 1'b0;
    logic             abort = 1'b0;
    logic [CNT_W-1:0] count;
    logic             busy;
    logic             done;

    int n_checks = 0;
    int n_errors = 0;
    int acc, dn, got;
    int unsigned fq[$];
    note_t       exp_notes[$];
    note_t       loop_seq[3] = '{8'd69, 8'd60, 8'd83};

    note_sequencer_if #(.FREQ_W(32), .NOTE_W(8)) bus ();

    note_sequencer #(
        .FREQ_W (32),
        .NOTE_W (8),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start_capture (start_capture),
        .start_play    (start_play),
        .loop_en       (loop_en),
        .abort         (abort),
        .bus           (bus),
        .count         (count),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
        n_checks++;
        if (got_v !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got_v, exp_v);
        end
    endtask

    task automatic run_capture(input bit use_last, output int accepted, output int dones);
        accepted = 0;
        dones    = 0;
        start_capture = 1'b1;
        tick();
        start_capture = 1'b0;
        check("cap_ready", bus.in_ready, 1);
        for (int i = 0; i < fq.size(); i++) begin
            bus.in_valid = 1'b1;
            bus.in_freq  = fq[i];
            bus.in_last  = use_last && (i == fq.size() - 1);
            if (bus.in_ready) accepted++;
            tick();
            if (done) dones++;
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        tick();
        if (done) dones++;
    endtask

    task automatic run_play(input bit rand_ready, input int exp_n, output int got_n, output int dones);
        got_n = 0;
        dones = 0;
        bus.out_ready = 1'b1;
        start_play = 1'b1;
        tick();
        start_play = 1'b0;
        check("play_busy", busy, 1);
        check("play_lat", bus.out_valid, 0);
        for (int cyc = 0; cyc < 200 && dones == 0; cyc++) begin
            tick();
            if (done) begin
                dones++;
                if (!rand_ready) check("play_done_cyc", cyc, exp_n);
            end
            if (!rand_ready && cyc < exp_n) check("play_nogap", bus.out_valid, 1);
            bus.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (bus.out_valid) begin
                if (got_n < exp_n) begin
                    check("play_note", bus.out_note, exp_notes[got_n]);
                    check("play_last", bus.out_last, (got_n == exp_n - 1));
                end else begin
                    check("play_extra", got_n, exp_n - 1);
                end
                if (bus.out_ready) got_n++;
            end
        end
        check("play_idle", busy, 0);
        check("play_valid_end", bus.out_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_freq   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_note", bus.out_note, 0);
        check("rst_out_last", bus.out_last, 0);
        check("rst_count", count, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        tick();

        // Basic phrase, one-shot playback
        fq = '{440, 262, 1000, 5};
        run_capture(1'b1, acc, dn);
        check("A_acc", acc, 4);
        check("A_cap_done", dn, 1);
        check("A_count", count, 4);
        check("A_busy", busy, 0);
        exp_notes = '{8'd69, 8'd60, 8'd83, 8'd0};
        run_play(1'b0, 4, got, dn);
        check("A_notes", got, 4);
        check("A_play_done", dn, 1);

        // Overfill: only DEPTH samples accepted, random backpressure on playback
        fq = '{254, 269, 285, 302, 320, 339, 359, 381, 403, 427, 453, 480,
               508, 539, 571, 605, 1000, 1000, 1000, 1000};
        run_capture(1'b0, acc, dn);
        check("B_acc", acc, 16);
        check("B_cap_done", dn, 1);
        check("B_count", count, 16);
        exp_notes = {};
        for (int i = 0; i < 16; i++) exp_notes.push_back(note_t'(60 + i));
        run_play(1'b1, 16, got, dn);
        check("B_notes", got, 16);
        check("B_play_done", dn, 1);

        // Table boundaries
        fq = '{15, 16, 12910, 12911, 20000, 440};
        run_capture(1'b1, acc, dn);
        check("C_count", count, 6);
        exp_notes = '{REST_CODE, 8'd12, 8'd127, OVER_CODE, OVER_CODE, 8'd69};
        run_play(1'b0, 6, got, dn);
        check("C_notes", got, 6);

        // Looping playback then abort
        fq = '{440, 262, 1000};
        run_capture(1'b1, acc, dn);
        check("D_count", count, 3);
        bus.out_ready = 1'b1;
        loop_en = 1'b1;
        start_play = 1'b1;
        tick();
        start_play = 1'b0;
        loop_en = 1'b0;
        check("D_lat", bus.out_valid, 0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("D_valid", bus.out_valid, 1);
            check("D_note", bus.out_note, loop_seq[i % 3]);
            check("D_last", bus.out_last, (i % 3 == 2));
            check("D_nodone", done, 0);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("D_abort_valid", bus.out_valid, 0);
        check("D_abort_busy", busy, 0);
        check("D_abort_done", done, 0);
        check("D_abort_count", count, 3);
        tick();
        check("D_abort_done2", done, 0);

        // Abort mid-capture keeps the entries written so far
        start_capture = 1'b1;
        tick();
        start_capture = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_freq  = 5;
        repeat (3) tick();
        bus.in_valid = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("E_count", count, 3);
        check("E_busy", busy, 0);
        check("E_in_ready", bus.in_ready, 0);
        check("E_done", done, 0);
        exp_notes = '{REST_CODE, REST_CODE, REST_CODE};
        run_play(1'b0, 3, got, dn);
        check("E_notes", got, 3);

        // Asynchronous reset mid-capture
        start_capture = 1'b1;
        tick();
        start_capture = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_freq  = 440;
        repeat (2) tick();
        #2 reset_n = 1'b0;
        #1;
        check("F_rst_in_ready", bus.in_ready, 0);
        check("F_rst_busy", busy, 0);
        check("F_rst_count", count, 0);
        check("F_rst_valid", bus.out_valid, 0);
        bus.in_valid = 1'b0;
        @(negedge clk) reset_n = 1'b1;
        tick();

        // Playback of an empty buffer
        start_play = 1'b1;
        tick();
        start_play = 1'b0;
        check("F_empty_done", done, 1);
        check("F_empty_valid", bus.out_valid, 0);
        check("F_empty_busy", busy, 0);
        tick();
        check("F_empty_done2", done, 0);
        check("F_empty_valid2", bus.out_valid, 0);

        // Simultaneous starts: capture wins
        start_capture = 1'b1;
        start_play    = 1'b1;
        tick();
        start_capture = 1'b0;
        start_play    = 1'b0;
        check("G_busy", busy, 1);
        check("G_in_ready", bus.in_ready, 1);
        tick();
        check("G_no_play", bus.out_valid, 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("G_idle", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
